riscv_mc_control: RTL and testbench
===================================

Name: riscv_mc_control

Overview:
- Multicycle main controller for the RISC-V core. It sits directly upstream of RegisterFile and ALU.
- Takes the opcode and funct fields of the latched instruction plus the ALU Zero flag.
- Sequences fetch, decode, execute, memory and writeback.
- Drives register-file write enable, ALUControl, datapath mux selects, and PC/IR/memory write enables.

Parameters:
- ALUCTRL_W, 2, width of alu_control. Must be >= 2; bits above [1:0] are driven 0.
- STATE_W, 4, width of the state register and the state_dbg port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset: 0 = in reset.
- op  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory handshake. Used only with MEM_READY_EN; ignored otherwise.
- pc_write  out  1  PC register write enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register write enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = RD1.
- alu_src_b  out  2  ALU B select: 00 = RD2, 01 = immediate, 10 = constant 4.
- reg_write  out  1  drives RegisterFile WE3.
- alu_control  out  ALUCTRL_W  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = or.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Moore FSM. All outputs decode from the state register only, except:
  - pc_write in BEQ (= zero);
  - alu_control in EXECUTER/EXECUTEI (decoded from funct fields);
  - write enables under MEM_READY_EN (see Optional Feature).
- States: S_RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
- Reset (reset = 0): state forced to S_RESET asynchronously. In S_RESET every output is 0 and state_dbg = S_RESET. First clk edge after reset = 1 moves to FETCH.
- Reset asserted mid-instruction: abort immediately; write enables drop to 0 in the same cycle, with no partial writeback.
- Per-state outputs (outputs not listed are 0; alu_control = add unless stated):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - anything else -> FETCH with illegal_op=1; no register or memory write.
  - MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1, instr_done=1. Next: FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1. Next: ALUWB (writes PC+4 to rd).
  - BEQ: alu_src_a=10, alu_src_b=00, alu_control=sub, result_src=00, pc_write=zero, instr_done=1. Next: FETCH.
- ALU decode (EXECUTER/EXECUTEI):
  - funct3 000: sub if R-type and funct7b5=1; otherwise add (addi ignores funct7b5).
  - funct3 111: and.
  - funct3 110: or.
  - any other funct3: add; the instruction still completes, with no flag.
- Latency in cycles, FETCH through final state: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.

Optional Feature:
- Macro: RISCV_MC_MEM_READY_EN.
- Defined: FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - ir_write, pc_write (FETCH) and mem_write (MEMWRITE) are asserted only in the cycle mem_ready=1.
  - The state advances on the edge where mem_ready=1.
  - mem_ready may stay high continuously (zero wait states).
- Undefined: mem_ready is ignored; each of these states lasts exactly one cycle.

Decomposition:
- Package riscv_mc_pkg holds:
  - state encoding constants;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - ALU encodings (ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11);
  - result_src / alu_src_a / alu_src_b select encodings.
- Sub-module riscv_alu_decoder: combinational; inputs funct3, funct7b5, is_rtype, force_sub; output alu_control.

Test Plan:
- Hold reset=0 for 3 cycles, then release -> all outputs 0 while in reset; state_dbg FETCH after first edge; pc_write=ir_write=1 in FETCH.
- op=0110011, funct3=000, funct7b5=1 -> states FETCH, DECODE, EXECUTER, ALUWB; alu_control=01 in EXECUTER; reg_write=1 only in ALUWB; instr_done 1 cycle.
- op=0000011 -> 5 cycles; result_src=01 and reg_write=1 in MEMWB. Then op=0100011 -> mem_write=1 exactly one cycle; reg_write never 1.
- op=1100011 with zero=1, then zero=0 -> pc_write=1 in BEQ when zero=1 and 0 when zero=0; alu_control=01; 3 cycles each.
- op=0000000 -> illegal_op=1 in DECODE; back to FETCH next cycle; reg_write and mem_write stay 0. Also: drive reset=0 during MEMWB -> reg_write drops to 0 immediately.
- With RISCV_MC_MEM_READY_EN defined, mem_ready=0 for 3 cycles in FETCH -> state holds and ir_write=0 for those cycles; advances with ir_write=1 on the cycle mem_ready=1.

Source files
------------

// File: rtl/riscv_mc_control_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operations and datapath mux selects.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/riscv_mc_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath side
// that supplies instruction fields / flags and consumes the control lines.
interface riscv_mc_if #(
    parameter int ALUCTRL_W = 2,
    parameter int STATE_W   = 4
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic                 reg_write;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 instr_done;
    logic                 illegal_op;
    logic [STATE_W-1:0]   state_dbg;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, reg_write, alu_control, instr_done, illegal_op, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, reg_write, alu_control, instr_done, illegal_op, state_dbg
    );
endinterface

// File: rtl/riscv_mc_control_alu_decoder.sv
// Combinational ALU operation decode from funct fields; force_sub overrides
// for branch compare.
module riscv_alu_decoder
    import riscv_mc_pkg::*;
#(
    parameter int ALUCTRL_W = 2
) (
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 is_rtype,
    input  logic                 force_sub,
    output logic [ALUCTRL_W-1:0] alu_control
);
    logic [1:0] w_op;

    always_comb begin
        w_op = ALU_ADD;
        if (force_sub) begin
            w_op = ALU_SUB;
        end else begin
            case (funct3)
                // addi has no funct7 field, so only R-type may select sub
                3'b000:  w_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b111:  w_op = ALU_AND;
                3'b110:  w_op = ALU_OR;
                default: w_op = ALU_ADD;
            endcase
        end
        alu_control      = '0;
        alu_control[1:0] = w_op;
    end
endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V main controller (Moore FSM). Optional memory wait states
// are enabled with `define RISCV_MC_MEM_READY_EN.
module riscv_mc_control
    import riscv_mc_pkg::*;
#(
    parameter int ALUCTRL_W = 2,
    parameter int STATE_W   = 4
) (
    input  logic     clk,
    input  logic     reset,
    riscv_mc_if.master bus
);
    state_t               r_state;
    state_t               w_state_next;
    logic                 w_mem_ok;
    logic [ALUCTRL_W-1:0] w_dec_alu;

    logic                 w_pc_write;
    logic                 w_adr_src;
    logic                 w_mem_write;
    logic                 w_ir_write;
    logic [1:0]           w_result_src;
    logic [1:0]           w_alu_src_a;
    logic [1:0]           w_alu_src_b;
    logic                 w_reg_write;
    logic [ALUCTRL_W-1:0] w_alu_control;
    logic                 w_instr_done;
    logic                 w_illegal_op;

`ifdef RISCV_MC_MEM_READY_EN
    assign w_mem_ok = bus.mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    // Outputs decode from r_state, so an async reset kills writes in-cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RESET;
        else        r_state <= w_state_next;
    end

    riscv_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .is_rtype    (r_state == S_EXECUTER),
        .force_sub   (r_state == S_BEQ),
        .alu_control (w_dec_alu)
    );

    always_comb begin
        w_state_next  = S_FETCH;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_result_src  = RES_ALUOUT;
        w_alu_src_a   = SRCA_PC;
        w_alu_src_b   = SRCB_RD2;
        w_reg_write   = 1'b0;
        w_alu_control = '0;
        w_instr_done  = 1'b0;
        w_illegal_op  = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_adr_src    = 1'b0;
                w_ir_write   = w_mem_ok;
                w_pc_write   = w_mem_ok;
                w_alu_src_a  = SRCA_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_state_next = w_mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_R:         w_state_next = S_EXECUTER;
                    OP_I:         w_state_next = S_EXECUTEI;
                    OP_JAL:       w_state_next = S_JAL;
                    OP_BEQ:       w_state_next = S_BEQ;
                    default: begin
                        w_state_next = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_IMM;
                w_state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                w_state_next = w_mem_ok ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = RES_MEMDATA;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_result_src = RES_ALUOUT;
                w_mem_write  = w_mem_ok;
                w_instr_done = w_mem_ok;
                w_state_next = w_mem_ok ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                w_alu_src_a   = SRCA_RD1;
                w_alu_src_b   = SRCB_RD2;
                w_alu_control = w_dec_alu;
                w_state_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a   = SRCA_RD1;
                w_alu_src_b   = SRCB_IMM;
                w_alu_control = w_dec_alu;
                w_state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_write   = 1'b1;
                w_state_next = S_ALUWB;
            end
            S_BEQ: begin
                w_alu_src_a   = SRCA_RD1;
                w_alu_src_b   = SRCB_RD2;
                w_alu_control = w_dec_alu;
                w_result_src  = RES_ALUOUT;
                w_pc_write    = bus.zero;
                w_instr_done  = 1'b1;
                w_state_next  = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.adr_src     = w_adr_src;
    assign bus.mem_write   = w_mem_write;
    assign bus.ir_write    = w_ir_write;
    assign bus.result_src  = w_result_src;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.reg_write   = w_reg_write;
    assign bus.alu_control = w_alu_control;
    assign bus.instr_done  = w_instr_done;
    assign bus.illegal_op  = w_illegal_op;
    assign bus.state_dbg   = STATE_W'(r_state);
endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: directed and random instructions
// against a per-instruction expected-cycle model built from the state table.
`timescale 1ns/1ps
module tb_riscv_mc_control;
    import riscv_mc_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    riscv_mc_if #(.ALUCTRL_W(2), .STATE_W(4)) bus ();

    riscv_mc_control #(.ALUCTRL_W(2), .STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] o;
    } row_t;

    row_t exp_q[$];

    // {pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b,
    //  reg_write, alu_control, instr_done, illegal_op}
    function automatic logic [14:0] pk(logic pcw, logic adr, logic mw, logic irw,
                                       logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                       logic rw, logic [1:0] alu, logic done, logic ill);
        return {pcw, adr, mw, irw, rs, a, b, rw, alu, done, ill};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.alu_control,
                bus.instr_done, bus.illegal_op};
    endfunction

    function automatic logic [1:0] ref_alu(logic [6:0] op, logic [2:0] f3, logic f7);
        if (f3 == 3'b000) return (op == 7'b0110011 && f7) ? 2'b01 : 2'b00;
        if (f3 == 3'b111) return 2'b10;
        if (f3 == 3'b110) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z);
        logic [1:0] alu;
        alu = ref_alu(op, f3, f7);
        exp_q.delete();
        exp_q.push_back({S_FETCH, pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0, 0)});
        case (op)
            7'b0000011: begin
                exp_q.push_back({S_DECODE,  pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_MEMADR,  pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_MEMREAD, pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_MEMWB,   pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 1, 0)});
            end
            7'b0100011: begin
                exp_q.push_back({S_DECODE,   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_MEMADR,   pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_MEMWRITE, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0)});
            end
            7'b0110011: begin
                exp_q.push_back({S_DECODE,   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_EXECUTER, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, alu, 0, 0)});
                exp_q.push_back({S_ALUWB,    pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0)});
            end
            7'b0010011: begin
                exp_q.push_back({S_DECODE,   pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_EXECUTEI, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, alu, 0, 0)});
                exp_q.push_back({S_ALUWB,    pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0)});
            end
            7'b1101111: begin
                exp_q.push_back({S_DECODE, pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_JAL,    pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_ALUWB,  pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0)});
            end
            7'b1100011: begin
                exp_q.push_back({S_DECODE, pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0)});
                exp_q.push_back({S_BEQ,    pk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 1, 0)});
            end
            default:
                exp_q.push_back({S_DECODE, pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 1)});
        endcase
    endtask

    task automatic drive_mem_ready();
`ifdef RISCV_MC_MEM_READY_EN
        bus.mem_ready = 1'b1;
`else
        bus.mem_ready = 1'($urandom);
`endif
    endtask

    // Entered just after the edge that put the DUT in FETCH; leaves it the
    // same way for the following instruction.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int abort_idx);
        row_t r;
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        build(op, f3, f7, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            r = exp_q[i];
            bus.zero = (r.st == S_BEQ) ? z : 1'($urandom);
            drive_mem_ready();
            @(negedge clk);
            check($sformatf("%s c%0d state", name, i), 32'(bus.state_dbg), 32'(r.st));
            check($sformatf("%s c%0d outs", name, i), 32'(observed()), 32'(r.o));
            $display("txn %s op=%b f3=%b f7=%b z=%b cycle=%0d state=%0d",
                     name, op, f3, f7, z, i, bus.state_dbg);
            if (i == abort_idx) begin
                #1 reset = 1'b0;
                #1;
                check($sformatf("%s abort outs", name), 32'(observed()), 32'd0);
                check($sformatf("%s abort state", name), 32'(bus.state_dbg), 32'(S_RESET));
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0] op_tbl [0:6];

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        bus.op       = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;
        bus.mem_ready = 1'b1;
        op_tbl[0] = OP_LW;  op_tbl[1] = OP_SW;  op_tbl[2] = OP_R;
        op_tbl[3] = OP_I;   op_tbl[4] = OP_JAL; op_tbl[5] = OP_BEQ;
        op_tbl[6] = 7'b0000000;

        for (int i = 0; i < 3; i++) begin
            bus.op = 7'($urandom);
            bus.zero = 1'($urandom);
            @(negedge clk);
            check($sformatf("reset c%0d outs", i), 32'(observed()), 32'd0);
            check($sformatf("reset c%0d state", i), 32'(bus.state_dbg), 32'(S_RESET));
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("release state", 32'(bus.state_dbg), 32'(S_RESET));
        @(posedge clk);
        #1;

        run_instr("sub",   OP_R,   3'b000, 1'b1, 1'b0, -1);
        run_instr("lw",    OP_LW,  3'b010, 1'b0, 1'b0, -1);
        run_instr("sw",    OP_SW,  3'b010, 1'b0, 1'b0, -1);
        run_instr("beq_t", OP_BEQ, 3'b000, 1'b0, 1'b1, -1);
        run_instr("beq_n", OP_BEQ, 3'b000, 1'b0, 1'b0, -1);
        run_instr("ill",   7'b0000000, 3'b000, 1'b0, 1'b0, -1);
        run_instr("addi",  OP_I,   3'b000, 1'b1, 1'b0, -1);
        run_instr("and",   OP_R,   3'b111, 1'b0, 1'b0, -1);
        run_instr("ori",   OP_I,   3'b110, 1'b0, 1'b0, -1);
        run_instr("xor",   OP_R,   3'b100, 1'b1, 1'b0, -1);
        run_instr("jal",   OP_JAL, 3'b000, 1'b0, 1'b0, -1);
        run_instr("lw_abort", OP_LW, 3'b010, 1'b0, 1'b0, 4);
        run_instr("post_abort", OP_R, 3'b000, 1'b0, 1'b0, -1);

`ifdef RISCV_MC_MEM_READY_EN
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall c%0d state", i), 32'(bus.state_dbg), 32'(S_FETCH));
            check($sformatf("stall c%0d ir_write", i), 32'(bus.ir_write), 32'd0);
            check($sformatf("stall c%0d pc_write", i), 32'(bus.pc_write), 32'd0);
            @(posedge clk);
            #1;
        end
        run_instr("after_stall", OP_I, 3'b111, 1'b0, 1'b0, -1);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [6:0] rop;
            int sel;
            sel = int'($urandom_range(0, 7));
            rop = (sel == 7) ? 7'($urandom) : op_tbl[sel];
            run_instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom),
                      1'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
